// File: rtl/axi_pkg.sv
// Shared AXI4 types: address/data/strobe widths, burst and response encodings.
package axi_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [7:0]  len_t;
  typedef logic [2:0]  size_t;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespSlverr = 2'b10
  } resp_t;

endpackage

// File: rtl/axi_if.sv
// AXI4 bus bundle (no IDs, no user/qos/cache/prot sidebands).
interface axi_if;
  import axi_pkg::*;

  addr_t  araddr;
  len_t   arlen;
  size_t  arsize;
  burst_t arburst;
  logic   arvalid;
  logic   arready;

  data_t  rdata;
  resp_t  rresp;
  logic   rlast;
  logic   rvalid;
  logic   rready;

  addr_t  awaddr;
  len_t   awlen;
  size_t  awsize;
  burst_t awburst;
  logic   awvalid;
  logic   awready;

  data_t  wdata;
  strb_t  wstrb;
  logic   wlast;
  logic   wvalid;
  logic   wready;

  resp_t  bresp;
  logic   bvalid;
  logic   bready;

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rresp, rlast, rvalid,
    output awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rresp, rlast, rvalid,
    input  awready, wready, bresp, bvalid
  );

endinterface

// File: rtl/axi_burst_addr.sv
// Next-beat address for FIXED/INCR/WRAP bursts, plus illegal size/len detection.
module axi_burst_addr
  import axi_pkg::*;
(
  input  addr_t  addr,
  input  len_t   len,
  input  size_t  size,
  input  burst_t burst,
  output addr_t  next_addr,
  output logic   illegal
);

  addr_t step;
  addr_t incr_addr;
  addr_t wrap_mask;

  // Wrap window is (len+1) beats of (1<<size) bytes, aligned to its own size.
  always_comb begin
    step      = addr_t'(1) << size;
    incr_addr = addr + step;
    wrap_mask = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
    illegal   = (size > 3'd2);
    next_addr = addr;
    case (burst)
      BurstFixed: next_addr = addr;
      BurstIncr:  next_addr = incr_addr;
      BurstWrap: begin
        next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})) illegal = 1'b1;
      end
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 memory slave with independent read (AR/R) and write (AW/W/B) FSMs.
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter addr_t       BASE_ADDR      = 32'h0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic  aclk,
  input logic  areset,
  axi_if.slave s_axi
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  typedef logic [IdxW-1:0] idx_t;

  typedef enum logic {RIdle, RData} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  data_t mem [DEPTH];

  // 33-bit subtraction so the borrow flags addresses below the base.
  function automatic logic in_range(addr_t a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return !off[32] && (off[31:IdxW+2] == '0);
  endfunction

  function automatic idx_t word_idx(addr_t a);
    addr_t off;
    off = a - BASE_ADDR;
    return off[IdxW+1:2];
  endfunction

  // ---------------- read channel ----------------
  r_state_e r_state_q, r_state_d;
  addr_t    r_addr_q, r_addr_d, r_next_addr;
  len_t     r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  size_t    r_size_q, r_size_d;
  burst_t   r_burst_q, r_burst_d;
  logic     r_illegal, r_err, r_valid, r_last;

  axi_burst_addr u_r_addr (
    .addr      (r_addr_q),
    .len       (r_len_q),
    .size      (r_size_q),
    .burst     (r_burst_q),
    .next_addr (r_next_addr),
    .illegal   (r_illegal)
  );

  assign r_valid = (r_state_q == RData);
  assign r_last  = r_valid && (r_cnt_q == r_len_q);
  assign r_err   = r_illegal || !in_range(r_addr_q);

  assign s_axi.arready = (r_state_q == RIdle) && !areset;
  assign s_axi.rvalid  = r_valid;
  assign s_axi.rlast   = r_last;
  assign s_axi.rresp   = (r_valid && r_err) ? RespSlverr : RespOkay;
  // Combinational read of the array gives pre-write data on a same-cycle collision.
  assign s_axi.rdata   = (r_valid && !r_err) ? mem[word_idx(r_addr_q)] : '0;

  // Read FSM next state: capture AR, step address/beat count on each R handshake.
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    unique case (r_state_q)
      RIdle: begin
        if (s_axi.arvalid) begin
          r_addr_d  = s_axi.araddr;
          r_len_d   = s_axi.arlen;
          r_size_d  = s_axi.arsize;
          r_burst_d = s_axi.arburst;
          r_cnt_d   = '0;
          r_state_d = RData;
        end
      end
      RData: begin
        if (s_axi.rready) begin
          if (r_last) begin
            r_state_d = RIdle;
          end else begin
            r_addr_d = r_next_addr;
            r_cnt_d  = r_cnt_q + 8'd1;
          end
        end
      end
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state_q <= RIdle;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= BurstFixed;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
    end
  end

  // ---------------- write channel ----------------
  w_state_e w_state_q, w_state_d;
  addr_t    w_addr_q, w_addr_d, w_next_addr;
  len_t     w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  size_t    w_size_q, w_size_d;
  burst_t   w_burst_q, w_burst_d;
  logic     w_err_q, w_err_d;
  logic     w_illegal, w_beat_err, w_last, mem_we;
  idx_t     w_idx;

  axi_burst_addr u_w_addr (
    .addr      (w_addr_q),
    .len       (w_len_q),
    .size      (w_size_q),
    .burst     (w_burst_q),
    .next_addr (w_next_addr),
    .illegal   (w_illegal)
  );

  assign w_last     = (w_cnt_q == w_len_q);
  assign w_beat_err = w_illegal || !in_range(w_addr_q);
  assign w_idx      = word_idx(w_addr_q);

  assign s_axi.awready = (w_state_q == WIdle) && !areset;
  assign s_axi.wready  = (w_state_q == WData);
  assign s_axi.bvalid  = (w_state_q == WResp);
  assign s_axi.bresp   = w_err_q ? RespSlverr : RespOkay;

  // Write FSM next state; burst ends on beat count, wlast only feeds the error flag.
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    mem_we    = 1'b0;
    case (w_state_q)
      WIdle: begin
        if (s_axi.awvalid) begin
          w_addr_d  = s_axi.awaddr;
          w_len_d   = s_axi.awlen;
          w_size_d  = s_axi.awsize;
          w_burst_d = s_axi.awburst;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_state_d = WData;
        end
      end
      WData: begin
        if (s_axi.wvalid) begin
          mem_we = !w_beat_err;
          if (w_beat_err || (s_axi.wlast != w_last)) w_err_d = 1'b1;
          if (w_last) begin
            w_state_d = WResp;
          end else begin
            w_addr_d = w_next_addr;
            w_cnt_d  = w_cnt_q + 8'd1;
          end
        end
      end
      WResp: begin
        if (s_axi.bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= WIdle;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= BurstFixed;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
    end
  end

  // Memory array: optional clear on reset, otherwise byte-masked writes from the write FSM.
  always_ff @(posedge aclk) begin
    if (areset) begin
      if (CLEAR_ON_RESET) begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      end
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi.wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

endmodule
